// File: rtl/biu_constants_pkg.sv
// Shared BIU encodings for size, burst type and protection, plus burst-shape helpers.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  // Undefined-length INCR is served as a single beat.
  function automatic logic [4:0] biu_type2beats(biu_type_t t);
    case (t)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

  function automatic logic [4:0] biu_size2bytes(biu_size_t s);
    case (s)
      BYTE:    return 5'd1;
      HWORD:   return 5'd2;
      WORD:    return 5'd4;
      DWORD:   return 5'd8;
      QWORD:   return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic biu_is_wrap(biu_type_t t);
    return (t == WRAP4) || (t == WRAP8) || (t == WRAP16);
  endfunction

endpackage

// File: rtl/riscv_biu_burst_adr.sv
// Burst beat-address generator: holds the address of the next beat to issue and
// flags when that beat is the last one of the burst.
module riscv_biu_burst_adr
  import biu_constants_pkg::*;
#(
  parameter int PLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            advance_i,
  input  logic [PLEN-1:0] adr_i,
  input  biu_size_t       size_i,
  input  biu_type_t       type_i,
  output logic [PLEN-1:0] adr_o,
  output logic            last_o
);

  logic [PLEN-1:0] adr_r;
  logic [4:0]      cnt_r;
  logic [4:0]      beats;
  logic [PLEN-1:0] base;
  logic [PLEN-1:0] bytes;
  logic [PLEN-1:0] mask;
  logic [PLEN-1:0] nxt;

  // Wrapping bursts keep the upper bits and roll the offset field inside beats*bytes.
  always_comb begin
    beats = biu_type2beats(type_i);
    bytes = PLEN'(biu_size2bytes(size_i));
    mask  = (PLEN'(beats) * bytes) - PLEN'(1);
    base  = load_i ? adr_i : adr_r;
    if (biu_is_wrap(type_i)) nxt = (base & ~mask) | ((base + bytes) & mask);
    else                     nxt = base + bytes;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_r <= '0;
      cnt_r <= '0;
    end else if (load_i) begin
      adr_r <= advance_i ? nxt : adr_i;
      cnt_r <= advance_i ? 5'd1 : 5'd0;
    end else if (advance_i) begin
      adr_r <= nxt;
      cnt_r <= cnt_r + 5'd1;
    end
  end

  assign adr_o  = adr_r;
  assign last_o = (cnt_r == (beats - 5'd1));

endmodule

// File: rtl/riscv_biu_mem_rsp.sv
// BIU responder backed by a word-wide synchronous memory; serves single and
// fixed-length bursts with programmable wait states and per-beat error checks.
module riscv_biu_mem_rsp
  import biu_constants_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PLEN        = XLEN,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int BIUTAG_SIZE = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   biu_stb_i,
  output logic                   biu_stb_ack_o,
  output logic                   biu_d_ack_o,
  input  logic [PLEN-1:0]        biu_adri_i,
  output logic [PLEN-1:0]        biu_adro_o,
  input  biu_size_t              biu_size_i,
  input  biu_type_t              biu_type_i,
  input  logic                   biu_we_i,
  input  logic                   biu_lock_i,
  input  biu_prot_t              biu_prot_i,
  input  logic [XLEN-1:0]        biu_d_i,
  output logic [XLEN-1:0]        biu_q_o,
  output logic                   biu_ack_o,
  output logic                   biu_err_o,
  input  logic [BIUTAG_SIZE-1:0] biu_tagi_i,
  output logic [BIUTAG_SIZE-1:0] biu_tago_o
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [PLEN-1:0] ADR_LIMIT  = PLEN'(DEPTH * 4);
  localparam logic [3:0]      WAIT_LAST  = 4'(WAIT_STATES - 1);
  localparam logic [1:0]      S_IDLE     = 2'd0;
  localparam logic [1:0]      S_WAIT     = 2'd1;
  localparam logic [1:0]      S_BEAT     = 2'd2;

  logic [XLEN-1:0]        mem [DEPTH];
  logic [1:0]             state;
  logic [3:0]             wait_cnt;
  biu_size_t              size_r, cur_size;
  biu_type_t              type_r, cur_type;
  logic                   we_r, cur_we;
  logic [BIUTAG_SIZE-1:0] tag_r, cur_tag;
  logic                   accept, issue, issue_last, issue_err, misalign;
  logic                   vis_last_r, wr_en_r, gen_last;
  logic [PLEN-1:0]        gen_adr, issue_adr;
  logic [3:0]             issue_be, be_r;
  logic [AW-1:0]          rd_idx, wr_idx;
  logic                   unused_sig;

  // Handshake: a request is taken in any cycle where stb is high while IDLE;
  // each beat then shows ack or err for exactly one cycle, and on writes the
  // data presented in that beat cycle is consumed at its closing edge (d_ack).
  assign biu_stb_ack_o = biu_stb_i & (state == S_IDLE);
  assign accept        = biu_stb_ack_o;
  assign unused_sig    = ^{biu_lock_i, biu_prot_i};

  // A beat is prepared one cycle before it becomes visible on the outputs.
  always_comb begin
    cur_size   = (state == S_IDLE) ? biu_size_i : size_r;
    cur_type   = (state == S_IDLE) ? biu_type_i : type_r;
    cur_we     = (state == S_IDLE) ? biu_we_i : we_r;
    cur_tag    = (state == S_IDLE) ? biu_tagi_i : tag_r;
    issue_adr  = (state == S_IDLE) ? biu_adri_i : gen_adr;
    issue_last = (state == S_IDLE) ? (biu_type2beats(biu_type_i) == 5'd1) : gen_last;
    issue      = (accept && (WAIT_STATES == 0)) ||
                 ((state == S_WAIT) && (wait_cnt == WAIT_LAST)) ||
                 ((state == S_BEAT) && !vis_last_r);
    misalign   = 1'b0;
    issue_be   = 4'b0000;
    case (cur_size)
      BYTE:    issue_be = 4'b0001 << issue_adr[1:0];
      HWORD:   begin
        issue_be = issue_adr[1] ? 4'b1100 : 4'b0011;
        misalign = issue_adr[0];
      end
      WORD:    begin
        issue_be = 4'b1111;
        misalign = |issue_adr[1:0];
      end
      default: misalign = 1'b1;
    endcase
    issue_err  = misalign || (issue_adr >= ADR_LIMIT);
    rd_idx     = issue_adr[AW+1:2];
    wr_idx     = biu_adro_o[AW+1:2];
  end

  riscv_biu_burst_adr #(.PLEN(PLEN)) u_burst_adr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept),
    .advance_i (issue),
    .adr_i     (biu_adri_i),
    .size_i    (cur_size),
    .type_i    (cur_type),
    .adr_o     (gen_adr),
    .last_o    (gen_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      size_r      <= BYTE;
      type_r      <= SINGLE;
      we_r        <= 1'b0;
      tag_r       <= '0;
      vis_last_r  <= 1'b0;
      wr_en_r     <= 1'b0;
      be_r        <= '0;
      biu_ack_o   <= 1'b0;
      biu_err_o   <= 1'b0;
      biu_d_ack_o <= 1'b0;
      biu_adro_o  <= '0;
      biu_tago_o  <= '0;
      biu_q_o     <= '0;
    end else begin
      if (accept) begin
        size_r <= biu_size_i;
        type_r <= biu_type_i;
        we_r   <= biu_we_i;
        tag_r  <= biu_tagi_i;
      end
      case (state)
        S_IDLE: if (accept) begin
          state    <= (WAIT_STATES == 0) ? S_BEAT : S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) state <= S_BEAT;
        end
        S_BEAT: if (vis_last_r) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      biu_ack_o   <= issue && !issue_err;
      biu_err_o   <= issue && issue_err;
      biu_d_ack_o <= issue && cur_we;
      wr_en_r     <= issue && cur_we && !issue_err;
      if (issue) begin
        biu_adro_o <= issue_adr;
        biu_tago_o <= cur_tag;
        vis_last_r <= issue_last;
        be_r       <= issue_be;
        if (!cur_we && !issue_err) biu_q_o <= mem[rd_idx];
      end
    end
  end

  // Write data is taken at the close of the visible beat; reset cancels it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) mem[wr_idx][i*8 +: 8] <= biu_d_i[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_biu_mem_rsp.sv
// Directed bench for riscv_biu_mem_rsp: a zero-wait instance and a three-wait instance.
module tb_riscv_biu_mem_rsp;
  import biu_constants_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb0, stb3;
  logic [31:0] adri, d;
  biu_size_t   size;
  biu_type_t   typ;
  logic        we, lock;
  biu_prot_t   prot;
  logic [1:0]  tagi;

  logic        sa0, dack0, ack0, err0, sa3, dack3, ack3, err3;
  logic [31:0] q0, adro0, q3, adro3;
  logic [1:0]  tago0, tago3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_biu_mem_rsp #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .biu_stb_i(stb0), .biu_stb_ack_o(sa0), .biu_d_ack_o(dack0),
    .biu_adri_i(adri), .biu_adro_o(adro0), .biu_size_i(size), .biu_type_i(typ),
    .biu_we_i(we), .biu_lock_i(lock), .biu_prot_i(prot), .biu_d_i(d), .biu_q_o(q0),
    .biu_ack_o(ack0), .biu_err_o(err0), .biu_tagi_i(tagi), .biu_tago_o(tago0)
  );

  riscv_biu_mem_rsp #(.WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .biu_stb_i(stb3), .biu_stb_ack_o(sa3), .biu_d_ack_o(dack3),
    .biu_adri_i(adri), .biu_adro_o(adro3), .biu_size_i(size), .biu_type_i(typ),
    .biu_we_i(we), .biu_lock_i(lock), .biu_prot_i(prot), .biu_d_i(d), .biu_q_o(q3),
    .biu_ack_o(ack3), .biu_err_o(err3), .biu_tagi_i(tagi), .biu_tago_o(tago3)
  );

  // Single-beat transfer on dut0: accept cycle, then the beat cycle is sampled.
  task automatic xfer0(input logic [31:0] a, input biu_size_t s, input logic w,
                       input logic [31:0] wd, input logic [1:0] t,
                       output logic o_sa, output logic o_ack, output logic o_err,
                       output logic o_dack, output logic [31:0] o_q,
                       output logic [31:0] o_adr, output logic [1:0] o_tag);
    @(negedge clk);
    adri = a; size = s; typ = SINGLE; we = w; d = wd; tagi = t; stb0 = 1'b1;
    #1 o_sa = sa0;
    @(negedge clk);
    stb0 = 1'b0;
    o_ack = ack0; o_err = err0; o_dack = dack0; o_q = q0; o_adr = adro0; o_tag = tago0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stb0 = 1'b0; stb3 = 1'b0; adri = '0; d = '0; size = WORD; typ = SINGLE;
    we = 1'b0; lock = 1'b0; prot = '0; tagi = '0;
    repeat (3) @(negedge clk);
    checks++; if ({sa0, ack0, err0, dack0} !== 4'b0000) begin errors++; $display("FAIL rst_flags0: got %b want 0000", {sa0, ack0, err0, dack0}); end
    checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL rst_q0: got %h want 0", q0); end
    checks++; if ({adro0, tago0} !== 34'h0) begin errors++; $display("FAIL rst_adr_tag0: got %h want 0", {adro0, tago0}); end
    checks++; if ({sa3, ack3, err3, dack3, q3} !== 36'h0) begin errors++; $display("FAIL rst_dut3: got %h want 0", {sa3, ack3, err3, dack3, q3}); end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    logic sa, ack, err, dack; logic [31:0] q, ao; logic [1:0] to;
    xfer0(32'h10, WORD, 1'b1, 32'hDEADBEEF, 2'd2, sa, ack, err, dack, q, ao, to);
    checks++; if (sa !== 1'b1) begin errors++; $display("FAIL sw_wr_stb_ack: got %b want 1", sa); end
    checks++; if ({dack, ack, err} !== 3'b110) begin errors++; $display("FAIL sw_wr_acks: got %b want 110", {dack, ack, err}); end
    checks++; if (ao !== 32'h10 || to !== 2'd2) begin errors++; $display("FAIL sw_wr_adr_tag: got %h/%0d want 10/2", ao, to); end
    xfer0(32'h10, WORD, 1'b0, 32'h0, 2'd1, sa, ack, err, dack, q, ao, to);
    checks++; if ({sa, dack, ack, err} !== 4'b1010) begin errors++; $display("FAIL sw_rd_flags: got %b want 1010", {sa, dack, ack, err}); end
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_rd_q: got %h want deadbeef", q); end
    checks++; if (ao !== 32'h10 || to !== 2'd1) begin errors++; $display("FAIL sw_rd_adr_tag: got %h/%0d want 10/1", ao, to); end
  endtask

  task automatic test_byte_write();
    logic sa, ack, err, dack; logic [31:0] q, ao; logic [1:0] to;
    xfer0(32'h10, WORD, 1'b1, 32'h11223344, 2'd0, sa, ack, err, dack, q, ao, to);
    xfer0(32'h13, BYTE, 1'b1, 32'hAA5A5A5A, 2'd3, sa, ack, err, dack, q, ao, to);
    checks++; if ({dack, ack, err} !== 3'b110) begin errors++; $display("FAIL bw_acks: got %b want 110", {dack, ack, err}); end
    xfer0(32'h10, WORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if (q !== 32'hAA223344) begin errors++; $display("FAIL bw_merge: got %h want aa223344", q); end
  endtask

  task automatic test_wrap4();
    logic sa, ack, err, dack; logic [31:0] q, ao; logic [1:0] to;
    logic [31:0] ea[4];
    logic [31:0] eq[4];
    ea = '{32'h18, 32'h1C, 32'h10, 32'h14};
    eq = '{32'hA0A0_0018, 32'hA0A0_001C, 32'hA0A0_0010, 32'hA0A0_0014};
    for (int i = 0; i < 4; i++)
      xfer0(32'h10 + 32'(4 * i), WORD, 1'b1, 32'hA0A0_0010 + 32'(4 * i), 2'd0, sa, ack, err, dack, q, ao, to);
    @(negedge clk);
    adri = 32'h18; size = WORD; typ = WRAP4; we = 1'b0; tagi = 2'd3; stb0 = 1'b1;
    #1 checks++; if (sa0 !== 1'b1) begin errors++; $display("FAIL wrap_stb_ack: got %b want 1", sa0); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({ack0, err0, sa0} !== 3'b100) begin errors++; $display("FAIL wrap_flags%0d: got %b want 100", k, {ack0, err0, sa0}); end
      checks++; if (adro0 !== ea[k] || tago0 !== 2'd3) begin errors++; $display("FAIL wrap_adr%0d: got %h/%0d want %h/3", k, adro0, tago0, ea[k]); end
      checks++; if (q0 !== eq[k]) begin errors++; $display("FAIL wrap_q%0d: got %h want %h", k, q0, eq[k]); end
    end
    stb0 = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL wrap_end: got ack %b want 0", ack0); end
  endtask

  task automatic test_wait_states();
    @(negedge clk);
    adri = 32'h0; size = WORD; typ = INCR8; we = 1'b1; tagi = 2'd1; d = 32'h3000_0000; stb3 = 1'b1;
    #1 checks++; if (sa3 !== 1'b1) begin errors++; $display("FAIL ws_stb_ack: got %b want 1", sa3); end
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      checks++; if ({sa3, ack3, dack3} !== 3'b000) begin errors++; $display("FAIL ws_wait%0d: got %b want 000", w, {sa3, ack3, dack3}); end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      d = 32'h3000_0000 + 32'(k);
      checks++; if ({dack3, ack3, err3, sa3} !== 4'b1100) begin errors++; $display("FAIL ws_beat%0d: got %b want 1100", k, {dack3, ack3, err3, sa3}); end
      checks++; if (adro3 !== 32'(4 * k)) begin errors++; $display("FAIL ws_adr%0d: got %h want %h", k, adro3, 32'(4 * k)); end
    end
    @(negedge clk);
    adri = 32'h8; typ = SINGLE; we = 1'b0; tagi = 2'd2;
    #1 checks++; if (sa3 !== 1'b1) begin errors++; $display("FAIL ws_reaccept: got %b want 1", sa3); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stb3 = 1'b0;
    end
    @(negedge clk);
    checks++; if ({ack3, adro3, tago3} !== {1'b1, 32'h8, 2'd2}) begin errors++; $display("FAIL ws_rd_beat: got %b/%h/%0d want 1/8/2", ack3, adro3, tago3); end
    checks++; if (q3 !== 32'h3000_0002) begin errors++; $display("FAIL ws_rd_q: got %h want 30000002", q3); end
  endtask

  task automatic test_errors();
    logic sa, ack, err, dack; logic [31:0] q, ao; logic [1:0] to;
    logic [1:0]  ef[4];
    logic [31:0] ea[4];
    ef = '{2'b10, 2'b10, 2'b01, 2'b01};
    ea = '{32'hFF8, 32'hFFC, 32'h1000, 32'h1004};
    xfer0(32'hFF8, WORD, 1'b1, 32'h5555AAAA, 2'd0, sa, ack, err, dack, q, ao, to);
    xfer0(32'hFFC, WORD, 1'b1, 32'h12345678, 2'd0, sa, ack, err, dack, q, ao, to);
    xfer0(32'h0, WORD, 1'b1, 32'hCAFEF00D, 2'd0, sa, ack, err, dack, q, ao, to);
    @(negedge clk);
    adri = 32'hFF8; size = WORD; typ = INCR4; we = 1'b0; tagi = 2'd0; stb0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stb0 = 1'b0;
      checks++; if ({ack0, err0} !== ef[k] || adro0 !== ea[k]) begin errors++; $display("FAIL oor_beat%0d: got %b/%h want %b/%h", k, {ack0, err0}, adro0, ef[k], ea[k]); end
      if (k == 0) begin checks++; if (q0 !== 32'h5555AAAA) begin errors++; $display("FAIL oor_q0: got %h want 5555aaaa", q0); end end
      if (k == 1) begin checks++; if (q0 !== 32'h12345678) begin errors++; $display("FAIL oor_q1: got %h want 12345678", q0); end end
    end
    xfer0(32'h2, WORD, 1'b1, 32'hFFFFFFFF, 2'd1, sa, ack, err, dack, q, ao, to);
    checks++; if ({dack, ack, err} !== 3'b101 || ao !== 32'h2) begin errors++; $display("FAIL mis_word_wr: got %b/%h want 101/2", {dack, ack, err}, ao); end
    xfer0(32'h1, HWORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL mis_hword_rd: got %b want 01", {ack, err}); end
    xfer0(32'h0, DWORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL dword_rd: got %b want 01", {ack, err}); end
    xfer0(32'h0, WORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if (q !== 32'hCAFEF00D) begin errors++; $display("FAIL err_no_write: got %h want cafef00d", q); end
    xfer0(32'h2, HWORD, 1'b1, 32'hBEEF1234, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL hword_wr: got %b want 10", {ack, err}); end
    xfer0(32'h0, WORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if (q !== 32'hBEEFF00D) begin errors++; $display("FAIL hword_merge: got %h want beeff00d", q); end
  endtask

  task automatic test_reset_abort();
    logic sa, ack, err, dack; logic [31:0] q, ao; logic [1:0] to;
    for (int i = 0; i < 4; i++)
      xfer0(32'h40 + 32'(4 * i), WORD, 1'b1, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    @(negedge clk);
    adri = 32'h40; size = WORD; typ = INCR4; we = 1'b1; tagi = 2'd0; d = 32'h4000_0000; stb0 = 1'b1;
    @(negedge clk);
    stb0 = 1'b0;
    checks++; if ({dack0, ack0} !== 2'b11 || adro0 !== 32'h40) begin errors++; $display("FAIL ab_beat0: got %b/%h want 11/40", {dack0, ack0}, adro0); end
    @(negedge clk);
    d = 32'h4000_0001;
    checks++; if ({dack0, ack0} !== 2'b11 || adro0 !== 32'h44) begin errors++; $display("FAIL ab_beat1: got %b/%h want 11/44", {dack0, ack0}, adro0); end
    @(negedge clk);
    d = 32'h4000_0002; rst = 1'b1;
    @(negedge clk);
    checks++; if ({ack0, err0, dack0} !== 3'b000 || adro0 !== 32'h0) begin errors++; $display("FAIL ab_in_reset: got %b/%h want 000/0", {ack0, err0, dack0}, adro0); end
    @(negedge clk);
    checks++; if ({ack0, err0, dack0} !== 3'b000) begin errors++; $display("FAIL ab_no_ack: got %b want 000", {ack0, err0, dack0}); end
    rst = 1'b0; adri = 32'h40; typ = SINGLE; we = 1'b0; tagi = 2'd1; stb0 = 1'b1;
    #1 checks++; if (sa0 !== 1'b1) begin errors++; $display("FAIL ab_stb_ack: got %b want 1", sa0); end
    @(negedge clk);
    stb0 = 1'b0;
    checks++; if (ack0 !== 1'b1 || q0 !== 32'h4000_0000) begin errors++; $display("FAIL ab_rd40: got %b/%h want 1/40000000", ack0, q0); end
    xfer0(32'h44, WORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if (q !== 32'h4000_0001) begin errors++; $display("FAIL ab_rd44: got %h want 40000001", q); end
    xfer0(32'h48, WORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL ab_rd48: got %h want 0", q); end
    xfer0(32'h4C, WORD, 1'b0, 32'h0, 2'd0, sa, ack, err, dack, q, ao, to);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL ab_rd4c: got %h want 0", q); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_byte_write();
    test_wrap4();
    test_wait_states();
    test_errors();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
